// File: rtl/caravel_ips_wb_splitter_pkg.sv
// Shared types and constants for the caravel_ips wishbone splitter and its CSR block.
package caravel_ips_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   localparam logic [1:0]  CSR_STATUS       = 2'd0;
   localparam logic [1:0]  CSR_IRQ_EN       = 2'd1;
   localparam logic [1:0]  CSR_LAST_ERR_ADR = 2'd2;
   localparam logic [1:0]  CSR_TIMEOUT      = 2'd3;

   localparam logic [31:0] DATA_TIMEOUT     = 32'hBADC_0FFE;
   localparam logic [31:0] DATA_UNMAPPED    = 32'hDEAD_DEAD;

   localparam int          STATUS_UNMAP_BIT = 31;
   localparam int          IRQ_EN_ERR_BIT   = 16;

   localparam logic [3:0]  CSR_SLOT         = 4'hF;

   function automatic logic [31:0] byte_mask(input logic [3:0] sel);
      byte_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

endpackage

// File: rtl/caravel_ips_wb_splitter_if.sv
// Wishbone classic master-side bundle between the management SoC and the splitter.
interface caravel_ips_wb_splitter_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic        ack;

   modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
   modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/caravel_ips_wb_splitter_csr.sv
// Splitter CSRs: sticky error status (W1C), irq enables, last error address,
// access timeout, and the registered user IRQ lines.
module caravel_ips_wb_csr
   import caravel_ips_pkg::*;
#(
   parameter int         NSLV        = 4,
   parameter logic [7:0] TIMEOUT_RST = 8'd255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_en,
   input  logic [1:0]      adr_sel,
   input  logic [31:0]     wdat,
   input  logic [3:0]      sel,
   input  logic            err_set,
   input  logic [31:0]     err_mask,
   input  logic [31:0]     err_adr,
   input  logic [NSLV-1:0] slv_irq_i,
   output logic [31:0]     rdata,
   output logic [7:0]      timeout,
   output logic [2:0]      irq_o
);

   localparam logic [31:0] SLOT_MASK   = 32'((64'd1 << NSLV) - 64'd1);
   localparam logic [31:0] STATUS_MASK = SLOT_MASK | (32'd1 << STATUS_UNMAP_BIT);
   localparam logic [31:0] IRQEN_MASK  = SLOT_MASK | (32'd1 << IRQ_EN_ERR_BIT);

   logic [31:0] status_q, status_d;
   logic [31:0] irq_en_q, irq_en_d;
   logic [31:0] last_err_q, last_err_d;
   logic [7:0]  timeout_q, timeout_d;
   logic [2:0]  irq_q, irq_d;
   logic [31:0] bm_s;

   // Next-state for CSRs: error capture, then bus writes, then irq aggregation.
   always_comb begin
      status_d   = status_q;
      irq_en_d   = irq_en_q;
      last_err_d = last_err_q;
      timeout_d  = timeout_q;
      bm_s       = byte_mask(sel);
      if (err_set) begin
         status_d   = status_q | (err_mask & STATUS_MASK);
         last_err_d = err_adr;
      end else begin
         last_err_d = last_err_q;
      end
      if (wr_en) begin
         case (adr_sel)
            CSR_STATUS:  status_d = status_q & ~(wdat & bm_s & STATUS_MASK);
            CSR_IRQ_EN:  irq_en_d = (irq_en_q & ~(bm_s & IRQEN_MASK)) | (wdat & bm_s & IRQEN_MASK);
            CSR_TIMEOUT: timeout_d = sel[0] ? wdat[7:0] : timeout_q;
            default:     timeout_d = timeout_q;
         endcase
      end else begin
         timeout_d = timeout_q;
      end
      irq_d[0] = |(slv_irq_i & irq_en_q[NSLV-1:0]);
      irq_d[1] = irq_en_q[IRQ_EN_ERR_BIT] & (|status_q);
      irq_d[2] = 1'b0;
   end

   // Read mux for the CSR slot.
   always_comb begin
      case (adr_sel)
         CSR_STATUS:       rdata = status_q;
         CSR_IRQ_EN:       rdata = irq_en_q;
         CSR_LAST_ERR_ADR: rdata = last_err_q;
         CSR_TIMEOUT:      rdata = {24'd0, timeout_q};
         default:          rdata = 32'd0;
      endcase
   end

   // CSR state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q   <= 32'd0;
         irq_en_q   <= 32'd0;
         last_err_q <= 32'd0;
         timeout_q  <= TIMEOUT_RST;
         irq_q      <= 3'd0;
      end else begin
         status_q   <= status_d;
         irq_en_q   <= irq_en_d;
         last_err_q <= last_err_d;
         timeout_q  <= timeout_d;
         irq_q      <= irq_d;
      end
   end

   assign timeout = timeout_q;
   assign irq_o   = irq_q;

endmodule

// File: rtl/caravel_ips_wb_splitter.sv
// Wishbone classic splitter: registers one master request, routes it to an IP slot
// or the CSR slot, enforces the access timeout and returns a one-cycle ack.
module caravel_ips_wb_splitter
   import caravel_ips_pkg::*;
#(
   parameter int         NSLV        = 4,
   parameter int         SLOT_LSB    = 16,
   parameter logic [7:0] BASE_HI     = 8'h30,
   parameter logic [7:0] TIMEOUT_RST = 8'd255
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_n_i,
   caravel_ips_wb_splitter_if.slave wbs,
   output logic [NSLV-1:0]      slv_cyc_o,
   output logic [NSLV-1:0]      slv_stb_o,
   output logic                 slv_we_o,
   output logic [3:0]           slv_sel_o,
   output logic [15:0]          slv_adr_o,
   output logic [31:0]          slv_dat_o,
   input  logic [NSLV-1:0]      slv_ack_i,
   input  logic [NSLV*32-1:0]   slv_dat_i,
   input  logic [NSLV-1:0]      slv_irq_i,
   output logic [2:0]           irq_o
);

   state_e          state_q, state_d;
   logic [NSLV-1:0] stb_q, stb_d;
   logic            we_q, we_d;
   logic [3:0]      sel_q, sel_d;
   logic [31:0]     adr_q, adr_d;
   logic [31:0]     wdat_q, wdat_d;
   logic [31:0]     rdat_q, rdat_d;
   logic            ack_q, ack_d;
   logic [7:0]      cnt_q, cnt_d;

   logic [3:0]      slot_s;
   logic [NSLV-1:0] onehot_s;
   logic            is_ext_s, is_csr_s, ack_hit_s, timeout_hit_s;
   logic [31:0]     ack_dat_s, csr_rdata_s, err_mask_s, err_adr_s;
   logic [7:0]      timeout_s;
   logic            csr_we_s, err_set_s;

   // Address decode of the live request and slave-side ack/data selection.
   always_comb begin
      slot_s    = wbs.adr[SLOT_LSB+3:SLOT_LSB];
      ack_dat_s = 32'd0;
      for (int k = 0; k < NSLV; k++) begin
         onehot_s[k] = (slot_s == 4'(k));
         ack_dat_s   = ack_dat_s | ({32{stb_q[k]}} & slv_dat_i[32*k +: 32]);
      end
      is_ext_s      = (wbs.adr[31:24] == BASE_HI) && (|onehot_s);
      is_csr_s      = (wbs.adr[31:24] == BASE_HI) && (slot_s == CSR_SLOT);
      ack_hit_s     = |(slv_ack_i & stb_q);
      timeout_hit_s = (timeout_s != 8'd0) && (cnt_q == (timeout_s - 8'd1));
   end

   // Transaction FSM: next state, latched request, response data and error reporting.
   always_comb begin
      state_d    = state_q;
      stb_d      = stb_q;
      we_d       = we_q;
      sel_d      = sel_q;
      adr_d      = adr_q;
      wdat_d     = wdat_q;
      cnt_d      = cnt_q;
      ack_d      = 1'b0;
      rdat_d     = 32'd0;
      csr_we_s   = 1'b0;
      err_set_s  = 1'b0;
      err_mask_s = 32'd0;
      err_adr_s  = adr_q;
      case (state_q)
         ST_IDLE: begin
            if (wbs.cyc && wbs.stb) begin
               we_d   = wbs.we;
               sel_d  = wbs.sel;
               adr_d  = wbs.adr;
               wdat_d = wbs.dat_w;
               cnt_d  = 8'd0;
               if (is_ext_s) begin
                  stb_d   = onehot_s;
                  state_d = ST_ACCESS;
               end else if (is_csr_s) begin
                  csr_we_s = wbs.we;
                  rdat_d   = csr_rdata_s;
                  ack_d    = 1'b1;
                  state_d  = ST_RESP;
               end else begin
                  rdat_d     = DATA_UNMAPPED;
                  err_set_s  = 1'b1;
                  err_mask_s = 32'd1 << STATUS_UNMAP_BIT;
                  err_adr_s  = wbs.adr;
                  ack_d      = 1'b1;
                  state_d    = ST_RESP;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            cnt_d = cnt_q + 8'd1;
            // A slave ack in the expiry cycle still counts as a normal completion.
            if (ack_hit_s) begin
               stb_d   = {NSLV{1'b0}};
               rdat_d  = ack_dat_s;
               ack_d   = 1'b1;
               state_d = ST_RESP;
            end else if (timeout_hit_s) begin
               stb_d      = {NSLV{1'b0}};
               rdat_d     = DATA_TIMEOUT;
               err_set_s  = 1'b1;
               err_mask_s = 32'(stb_q);
               ack_d      = 1'b1;
               state_d    = ST_RESP;
            end else begin
               state_d = ST_ACCESS;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: begin
            state_d = ST_IDLE;
            stb_d   = {NSLV{1'b0}};
         end
      endcase
   end

   // Splitter state and registered outputs.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q <= ST_IDLE;
         stb_q   <= {NSLV{1'b0}};
         we_q    <= 1'b0;
         sel_q   <= 4'd0;
         adr_q   <= 32'd0;
         wdat_q  <= 32'd0;
         rdat_q  <= 32'd0;
         ack_q   <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         stb_q   <= stb_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
         ack_q   <= ack_d;
         cnt_q   <= cnt_d;
      end
   end

   caravel_ips_wb_csr #(
      .NSLV        (NSLV),
      .TIMEOUT_RST (TIMEOUT_RST)
   ) u_csr (
      .clk       (wb_clk_i),
      .rst_n     (wb_rst_n_i),
      .wr_en     (csr_we_s),
      .adr_sel   (wbs.adr[3:2]),
      .wdat      (wbs.dat_w),
      .sel       (wbs.sel),
      .err_set   (err_set_s),
      .err_mask  (err_mask_s),
      .err_adr   (err_adr_s),
      .slv_irq_i (slv_irq_i),
      .rdata     (csr_rdata_s),
      .timeout   (timeout_s),
      .irq_o     (irq_o)
   );

   assign wbs.ack   = ack_q;
   assign wbs.dat_r = rdat_q;
   assign slv_cyc_o = stb_q;
   assign slv_stb_o = stb_q;
   assign slv_we_o  = we_q;
   assign slv_sel_o = sel_q;
   assign slv_adr_o = adr_q[15:0];
   assign slv_dat_o = wdat_q;

endmodule

// File: doc/caravel_ips_wb_splitter.md
Name: caravel_ips_wb_splitter

Overview:
Wishbone classic bus splitter that sits inside caravel_ips, directly downstream of the management SoC wishbone slave port. It registers each master request, decodes it into one of NSLV IP slots or an internal CSR slot, and enforces a per-access timeout. It returns a single-cycle ack and aggregates IP interrupts onto the 3-bit user IRQ. Only one access is outstanding at a time.

Parameters:
NSLV, 4, number of external IP slots (1..8)
SLOT_LSB, 16, LSB of the 4-bit slot index field in wbs_adr_i
BASE_HI, 8'h30, required value of wbs_adr_i[31:24]
TIMEOUT_RST, 8'd255, reset value of the TIMEOUT CSR (cycles)

Ports:
wb_clk_i  in  1  bus clock; the block's only clock
wb_rst_n_i  in  1  reset, asynchronous assert, active-low
wbs_cyc_i  in  1  master cycle
wbs_stb_i  in  1  master strobe
wbs_we_i  in  1  master write enable
wbs_sel_i  in  4  master byte selects
wbs_adr_i  in  32  master address
wbs_dat_i  in  32  master write data
wbs_ack_o  out  1  master ack, one-cycle pulse
wbs_dat_o  out  32  master read data, valid while wbs_ack_o=1
slv_cyc_o  out  NSLV  per-slot cycle
slv_stb_o  out  NSLV  per-slot strobe, one-hot or zero
slv_we_o  out  1  registered write enable
slv_sel_o  out  4  registered byte selects
slv_adr_o  out  16  registered wbs_adr_i[15:0]
slv_dat_o  out  32  registered write data
slv_ack_i  in  NSLV  per-slot ack
slv_dat_i  in  NSLV*32  per-slot read data; slot k occupies [32k+31:32k]
slv_irq_i  in  NSLV  per-slot level interrupt
irq_o  out  3  user IRQ lines

Behaviour:
- Reset (async, wb_rst_n_i=0) clears the following immediately: all outputs 0, FSM to IDLE, STATUS=0, IRQ_EN=0, LAST_ERR_ADR=0, TIMEOUT=TIMEOUT_RST, counter=0.
- Decode: the address is mapped only if adr[31:24]==BASE_HI.
  - slot=adr[SLOT_LSB+3:SLOT_LSB]; slot<NSLV selects an external slot; slot==4'hF selects the CSR slot.
  - Anything else, including a BASE_HI mismatch, is unmapped.
- FSM states:
  - IDLE: when cyc&stb, latch adr/dat/we/sel and decode.
    - External slot → ACCESS, with slv_cyc_o[k]/slv_stb_o[k]=1 from the next cycle.
    - CSR slot or unmapped → RESP directly.
  - ACCESS: the counter increments each cycle.
    - slv_ack_i[k]=1 → capture slv_dat_i slot k, drop slv_cyc/stb next cycle, go to RESP.
    - Otherwise, when TIMEOUT!=0 and counter==TIMEOUT-1: drop stb, set STATUS[k], LAST_ERR_ADR=latched adr, go to RESP with data 32'hBADC_0FFE.
    - If ack and timeout expiry coincide, ack wins: normal data, no flag.
    - TIMEOUT==0 disables the timeout.
  - RESP: wbs_ack_o=1 for exactly this cycle, with wbs_dat_o driven. wbs_cyc/stb are ignored in RESP (no double-issue). Next state is IDLE.
- Latency: external access with a 1-cycle slave ack gives master ack 3 cycles after the request is seen. CSR and unmapped accesses give master ack 1 cycle after.
- Unmapped access: wbs_dat_o=32'hDEAD_DEAD, STATUS[31] set, LAST_ERR_ADR=adr, writes dropped.
- Dropping wbs_cyc_i mid-ACCESS does not abort the access. It completes normally, and the ack is still pulsed.
- CSR map, selected by adr[3:2]; byte writes honour sel:
  - 0x0 STATUS: bits[NSLV-1:0] are timeout sticky per slot; bit31 is unmapped sticky; write-1-to-clear.
  - 0x4 IRQ_EN: bits[NSLV-1:0] are per-slot irq enables; bit16 is the error irq enable.
  - 0x8 LAST_ERR_ADR: read-only.
  - 0xC TIMEOUT: bits[7:0] read/write; upper bits read 0.
- No set/clear conflict is possible: a STATUS set occurs only in ACCESS or unmapped RESP, and a W1C occurs only in CSR RESP.
- irq_o is registered (1-cycle latency):
  - irq_o[0] = |(slv_irq_i & IRQ_EN[NSLV-1:0])
  - irq_o[1] = IRQ_EN[16] & |STATUS
  - irq_o[2] = 0

Decomposition:
- Package caravel_ips_pkg holds:
  - FSM state enum (IDLE/ACCESS/RESP)
  - CSR offsets
  - error data constants BADC_0FFE and DEAD_DEAD
  - STATUS bit positions
  - CSR slot index 4'hF
- One sub-module, caravel_ips_wb_csr, contains the CSR registers, W1C logic and irq_o generation.

Test Plan:
- Write 0x3001_0004 ← 0x1234_5678, slot1 acks 1 cycle after stb → slv_stb_o=4'b0010, slv_adr_o=16'h0004, slv_dat_o=0x1234_5678, single wbs_ack_o 3 cycles after the request.
- Read slot2, slave returns 0xCAFE_F00D after 5 cycles → wbs_dat_o=0xCAFE_F00D, STATUS=0.
- TIMEOUT=8, slot0 never acks → stb dropped after 8 cycles, wbs_dat_o=0xBADC_0FFE, STATUS[0]=1, LAST_ERR_ADR=0x3000_0010; with IRQ_EN[16]=1, irq_o[1]=1; writing STATUS←0x1 clears both.
- Ack arriving in the same cycle the timeout expires → normal data returned, STATUS[0] stays 0.
- Read 0x4000_0000 → wbs_dat_o=0xDEAD_DEAD one cycle later, STATUS[31]=1; stb held high through RESP produces no second ack.
- Assert wb_rst_n_i low mid-ACCESS → slv_stb_o=0 immediately, TIMEOUT reads 255, following access works normally.
